// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer, one round per clock.
// Drives an external combinational round datapath and key store.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     block handshake; message is the plaintext
//   abort                 synchronous cancel of any operation
//   rk_idx/rk_key         round-key request and combinational reply
//   dp_in/dp_last/dp_out  round datapath drive, final-round flag, result
//   crypte/out_valid      ciphertext and its valid flag
//   out_ready             consumer takes the ciphertext
//   busy                  an operation occupies the controller
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] message,
    input  logic         abort,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk_key,
    output logic [0:127] dp_in,
    output logic         dp_last,
    input  logic [0:127] dp_out,
    output logic [0:127] crypte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] LAST = 4'(NR);

    logic [1:0]   state;
    logic [0:127] st;
    logic [3:0]   rnd;
    logic         is_last;

    assign is_last = (rnd == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            st    <= '0;
            rnd   <= 4'd0;
        end else if (abort) begin
            // Cancel wins over accept and over consume.
            state <= IDLE;
            st    <= '0;
            rnd   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Initial AddRoundKey with round key 0.
                        st    <= message ^ rk_key;
                        rnd   <= 4'd1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    st <= dp_out;
                    if (is_last) begin
                        state <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        st    <= '0;
                        rnd   <= 4'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    st    <= '0;
                    rnd   <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'd0;
        dp_in     = '0;
        dp_last   = 1'b0;
        crypte    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            ROUND: begin
                busy    = 1'b1;
                rk_idx  = rnd;
                dp_in   = st;
                dp_last = is_last;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                crypte    = st;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
